// File: rtl/spi_reg_ctrl_if.sv
// Bus between the byte-level spi slave / pin side and the register sequencer.
interface spi_reg_ctrl_if #(
  parameter int unsigned NREGS = 16
);
  logic                 ss;
  logic [7:0]           rx_byte;
  logic                 rx_done;
  logic [7:0]           tx_byte;
  logic [NREGS*8-1:0]   regs;
  logic                 wr_stb;
  logic [6:0]           wr_addr;
  logic                 busy;

  // Side that feeds ss and received bytes, and consumes the register outputs.
  modport master (
    output ss, rx_byte, rx_done,
    input  tx_byte, regs, wr_stb, wr_addr, busy
  );

  // The register sequencer.
  modport slave (
    input  ss, rx_byte, rx_done,
    output tx_byte, regs, wr_stb, wr_addr, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command sequencer: turns ss-framed byte streams from the spi slave into
// reads/writes of an NREGS x 8 register file. Byte 0 of a frame is
// {rw, addr[6:0]}; following bytes are data with auto-incrementing address.
// Address 0 is a read-only ID register.
module spi_reg_ctrl #(
  parameter int unsigned NREGS    = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  spi_reg_ctrl_if.slave bus
);

  localparam int unsigned AW     = $clog2(NREGS);
  localparam logic [7:0]  NREGS8 = 8'(NREGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state, nxt_state;
  logic        rw, nxt_rw;
  logic [6:0]  addr, nxt_addr;
  logic [7:0]  tx_byte, nxt_tx;
  logic        we;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic        ss_meta, ss_s;
  logic        done_q, done_q2;
  logic        byte_ev;
  logic [7:0]  mem [1:NREGS-1];

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < NREGS8);
  endfunction

  function automatic logic [7:0] rd(input logic [6:0] a);
    if (a == 7'd0)
      return ID_VALUE;
    else if (in_range(a))
      return mem[a[AW-1:0]];
    else
      return 8'h00;
  endfunction

  // Two-flop ss synchronizer (idles high) and rx_done edge-detect flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta <= 1'b1;
      ss_s    <= 1'b1;
      done_q  <= 1'b0;
      done_q2 <= 1'b0;
    end else begin
      ss_meta <= bus.ss;
      ss_s    <= ss_meta;
      done_q  <= bus.rx_done;
      done_q2 <= done_q;
    end
  end

  assign byte_ev = done_q & ~done_q2;

  // Sequencer state, command fields and outgoing byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rw      <= 1'b0;
      addr    <= '0;
      tx_byte <= ID_VALUE;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      state   <= nxt_state;
      rw      <= nxt_rw;
      addr    <= nxt_addr;
      tx_byte <= nxt_tx;
      wr_stb  <= we;
      if (we)
        wr_addr <= addr;
    end
  end

  // Next-state logic; the frame-close override sits after the case so a
  // byte arriving on the closing clock is still handled (write lands).
  always_comb begin
    nxt_state = state;
    nxt_rw    = rw;
    nxt_addr  = addr;
    nxt_tx    = tx_byte;
    we        = 1'b0;
    case (state)
      IDLE: begin
        nxt_tx = ID_VALUE;
        if (!ss_s)
          nxt_state = CMD;
      end
      CMD: begin
        if (byte_ev) begin
          nxt_rw    = bus.rx_byte[7];
          nxt_addr  = bus.rx_byte[6:0];
          nxt_state = DATA;
          if (bus.rx_byte[7]) begin
            nxt_tx   = rd(bus.rx_byte[6:0]);
            nxt_addr = bus.rx_byte[6:0] + 7'd1;
          end else begin
            nxt_tx = 8'h00;
          end
        end
      end
      DATA: begin
        if (byte_ev) begin
          nxt_addr = addr + 7'd1;
          if (rw) begin
            nxt_tx = rd(addr);
          end else begin
            nxt_tx = 8'h00;
            we     = (addr != 7'd0) && in_range(addr);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (ss_s) begin
      nxt_state = IDLE;
      nxt_tx    = ID_VALUE;
    end
  end

  // Register file write port; entry 0 does not exist (ID is a constant).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < NREGS; i++)
        mem[i[AW-1:0]] <= '0;
    end else if (we) begin
      mem[addr[AW-1:0]] <= bus.rx_byte;
    end
  end

  // Flatten the register file onto the output bus, reg 0 tied to the ID.
  always_comb begin
    bus.regs      = '0;
    bus.regs[7:0] = ID_VALUE;
    for (int unsigned i = 1; i < NREGS; i++)
      bus.regs[8*i +: 8] = mem[i[AW-1:0]];
  end

  assign bus.tx_byte = tx_byte;
  assign bus.wr_stb  = wr_stb;
  assign bus.wr_addr = wr_addr;
  assign bus.busy    = (state != IDLE);

endmodule
